// File: rtl/ibuffer_queue.sv
// ibuffer_queue: circular instruction buffer between predecode and decode, flushed on redirect.
// Optional same-cycle bypass of an empty queue is enabled by defining IBUF_BYPASS_EN.
module ibuffer_queue #(
  parameter int DEPTH     = 16,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 4,
  parameter int IDX_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_WIDTH-1:0]          in_en,
  input  logic [$clog2(IN_WIDTH):0]    in_num,
  input  logic [IN_WIDTH*32-1:0]       in_inst,
  input  logic [IDX_W-1:0]             in_fsqIdx,
  input  logic                         flush,
  input  logic                         out_stall,
  output logic [OUT_WIDTH-1:0]         out_en,
  output logic [OUT_WIDTH*32-1:0]      out_inst,
  output logic [OUT_WIDTH*IDX_W-1:0]   out_fsqIdx,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int NW = $clog2(IN_WIDTH) + 1;
  localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [PW:0]   IN_W_W  = (PW+1)'(IN_WIDTH);
  localparam logic [PW-1:0] OUT_W_P = PW'(OUT_WIDTH);
  localparam logic [NW-1:0] OUT_W_N = NW'(OUT_WIDTH);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic             full_q, full_d;
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [IDX_W-1:0] fsq_q  [DEPTH];
  logic [IDX_W-1:0] fsq_d  [DEPTH];

  logic [PW-1:0]    count_s, count_next_s, deq_num_s, wr_num_s;
  logic [NW-1:0]    rank_s [IN_WIDTH];
  logic [NW-1:0]    byp_num_s;
  logic             kill_s, enq_fire_s;

  // Reset behaves exactly like a flush for the combinational view.
  assign kill_s  = flush | rst;
  assign count_s = tail_q - head_q;
  assign full    = full_q;

  // Number of set slots below each input slot, i.e. its compacted position.
  always_comb begin
    logic [NW-1:0] acc;
    acc = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      rank_s[i] = acc;
      acc       = acc + NW'(in_en[i]);
    end
  end

`ifdef IBUF_BYPASS_EN
  logic [31:0]          comp_inst_s [IN_WIDTH];
  logic [IN_WIDTH-1:0]  comp_valid_s;
  logic                 byp_active_s;

  assign byp_active_s = (count_s == '0) && !kill_s;

  // Compacted input view; ranks are unique so the OR acts as a one-hot mux.
  always_comb begin
    comp_valid_s = '0;
    for (int j = 0; j < IN_WIDTH; j++) begin
      comp_inst_s[j] = 32'h0000_0000;
      for (int i = 0; i < IN_WIDTH; i++) begin
        comp_valid_s[j] = comp_valid_s[j] | (in_en[i] && (rank_s[i] == NW'(j)));
        comp_inst_s[j]  = comp_inst_s[j] |
                          ((in_en[i] && (rank_s[i] == NW'(j))) ? in_inst[32*i +: 32] : 32'h0000_0000);
      end
    end
  end
`endif

  // Pointer movement, compacted storage writes and the next full flag.
  always_comb begin
    logic             wr_ok;
    logic [AW-1:0]    wr_idx;
    enq_fire_s = (|in_en) && !full_q && !kill_s;
`ifdef IBUF_BYPASS_EN
    byp_num_s  = (byp_active_s && enq_fire_s && !out_stall) ?
                 ((in_num > OUT_W_N) ? OUT_W_N : in_num) : '0;
`else
    byp_num_s  = '0;
`endif
    wr_num_s   = enq_fire_s ? PW'(in_num - byp_num_s) : '0;
    deq_num_s  = (out_stall || kill_s) ? '0 : ((count_s > OUT_W_P) ? OUT_W_P : count_s);

    inst_d = inst_q;
    fsq_d  = fsq_q;
    for (int i = 0; i < IN_WIDTH; i++) begin
      wr_ok          = enq_fire_s && in_en[i] && (rank_s[i] >= byp_num_s);
      wr_idx         = tail_q[AW-1:0] + AW'(rank_s[i] - byp_num_s);
      inst_d[wr_idx] = wr_ok ? in_inst[32*i +: 32] : inst_d[wr_idx];
      fsq_d[wr_idx]  = wr_ok ? in_fsqIdx : fsq_d[wr_idx];
    end

    if (kill_s) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      head_d = head_q + deq_num_s;
      tail_d = tail_q + wr_num_s;
    end
    count_next_s = tail_d - head_d;
    full_d       = (DEPTH_W - {1'b0, count_next_s}) < IN_W_W;
  end

  // Read side: slot i shows entry head+i, or the compacted input when bypassing.
  always_comb begin
    logic [AW-1:0] rd_idx;
    out_en     = '0;
    out_inst   = '0;
    out_fsqIdx = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      rd_idx                       = head_q[AW-1:0] + AW'(i);
      out_en[i]                    = (count_s > PW'(i)) && !kill_s;
      out_inst[32*i +: 32]         = inst_q[rd_idx];
      out_fsqIdx[IDX_W*i +: IDX_W] = fsq_q[rd_idx];
    end
`ifdef IBUF_BYPASS_EN
    if (byp_active_s) begin
      for (int j = 0; j < OUT_WIDTH; j++) begin
        out_en[j]                    = comp_valid_s[j];
        out_inst[32*j +: 32]         = comp_inst_s[j];
        out_fsqIdx[IDX_W*j +: IDX_W] = in_fsqIdx;
      end
    end else begin
      out_en = out_en;
    end
`endif
  end

  // Pointer and full-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      full_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      full_q <= full_d;
    end
  end

  // Entry storage; contents are meaningless outside [head, tail).
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    fsq_q  <= fsq_d;
  end

  // Protocol and occupancy invariants.
  a_in_num: assert property (@(posedge clk) disable iff (rst)
    (|in_en) |-> (in_num == NW'($countones(in_en))));
  a_count:  assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count_s} <= DEPTH_W));

endmodule
